dsp_mac_sequencer: RTL and testbench

Command-driven sequencer for one DSP48A1 slice. It accepts a dot-product command of N terms and streams N operand pairs (A, B) into the slice. It drives OPMODE cycle-accurately so the slice accumulates the products, with optional C bias and optional subtraction. It then captures the 48-bit P result and presents it on a valid/ready port. It sits between a requester and a DSP48A1 built with A0REG=0, A1REG=1, B0REG=0, B1REG=1, CREG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT"; all DSP RST* inputs are tied to RST at the top level.

---
 rtl/dsp_mac_sequencer.sv | 155 +++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Command-driven sequencer feeding one DSP48A1 slice: streams N operand pairs,
// drives OPMODE so the slice accumulates (optionally biased/subtracted), then returns P.
module dsp_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_bias_en,
    input  logic             cmd_sub,
    input  logic [47:0]      cmd_bias,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_carryin,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data
);

    // OPMODE fields: bit7 = subtract, [3:2] = Z mux, [1:0] = X mux
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;
    localparam logic [7:0] OP_HOLD = {1'b0, 3'b000, Z_P, X_ZERO};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             bias_en_q, bias_en_d;
    logic             sub_q, sub_d;
    logic [47:0]      dsp_c_q, dsp_c_d;
    logic [7:0]       opmode_q, opmode_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic [47:0]      res_data_q, res_data_d;

    logic             accept;
    logic             cmd_hs;
    logic [1:0]       z_first;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign s_ready     = (state_q == ST_STREAM) && (cnt_q != '0);
    assign accept      = s_valid && s_ready;
    assign cmd_hs      = cmd_valid && cmd_ready;
    assign dsp_a       = accept ? s_a : 18'd0;
    assign dsp_b       = accept ? s_b : 18'd0;
    assign dsp_c       = dsp_c_q;
    assign dsp_opmode  = opmode_q;
    assign dsp_carryin = 1'b0;
    assign dsp_ce      = 1'b1;
    assign res_valid   = (state_q == ST_HOLD);
    assign res_data    = res_data_q;
    assign z_first     = bias_en_q ? Z_C : Z_ZERO;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        bias_en_d   = bias_en_q;
        sub_d       = sub_q;
        dsp_c_d     = dsp_c_q;
        opmode_d    = OP_HOLD;
        drain_cnt_d = drain_cnt_q;
        res_data_d  = res_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    cnt_d     = cmd_len;
                    first_d   = 1'b1;
                    bias_en_d = cmd_bias_en;
                    sub_d     = cmd_sub;
                    dsp_c_d   = cmd_bias;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (cnt_q == '0) begin
                    // Zero-length command: a single term that loads P with C or 0
                    opmode_d    = {1'b0, 3'b000, z_first, X_ZERO};
                    drain_cnt_d = 2'd0;
                    state_d     = ST_DRAIN;
                end else if (accept) begin
                    opmode_d = first_q ? {sub_q, 3'b000, z_first, X_M}
                                       : {sub_q, 3'b000, Z_P, X_M};
                    first_d  = 1'b0;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        drain_cnt_d = 2'd0;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Three cycles cover the OPMODE, M and P register stages of the slice
                if (drain_cnt_q == 2'd2) begin
                    res_data_d  = dsp_p;
                    drain_cnt_d = 2'd0;
                    state_d     = ST_HOLD;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            bias_en_q   <= 1'b0;
            sub_q       <= 1'b0;
            dsp_c_q     <= 48'd0;
            opmode_q    <= OP_HOLD;
            drain_cnt_q <= 2'd0;
            res_data_q  <= 48'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            bias_en_q   <= bias_en_d;
            sub_q       <= sub_d;
            dsp_c_q     <= dsp_c_d;
            opmode_q    <= opmode_d;
            drain_cnt_q <= drain_cnt_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: closes the loop through a DSP48A1 register model and
// checks results, latency and OPMODE against an arithmetic dot-product model.
module tb_dsp_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = 8'd0;
    logic        cmd_bias_en = 1'b0;
    logic        cmd_sub = 1'b0;
    logic [47:0] cmd_bias = 48'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [17:0] s_a = 18'd0;
    logic [17:0] s_b = 18'd0;
    logic [17:0] dsp_a, dsp_b;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin, dsp_ce;
    logic [47:0] dsp_p;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;

    int vectors = 0;
    int miscompares = 0;
    logic [47:0] exp_q[$];

    always #5 CLK = ~CLK;

    dsp_mac_sequencer #(.LEN_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_bias_en(cmd_bias_en), .cmd_sub(cmd_sub), .cmd_bias(cmd_bias),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
        .dsp_carryin(dsp_carryin), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // DSP48A1 model: A1/B1, C, M, P and OPMODE registers, all cleared by RST
    logic signed [17:0] a1_r, b1_r;
    logic signed [35:0] m_r;
    logic [47:0] c_r, p_r, x_mux, z_mux;
    logic [7:0]  op_r;

    assign x_mux = (op_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
    assign z_mux = (op_r[3:2] == 2'b10) ? p_r : (op_r[3:2] == 2'b11) ? c_r : 48'd0;
    assign dsp_p = p_r;

    always @(posedge CLK) begin
        if (RST) begin
            a1_r <= '0; b1_r <= '0; m_r <= '0; c_r <= '0; p_r <= '0; op_r <= '0;
        end else begin
            a1_r <= dsp_a;
            b1_r <= dsp_b;
            c_r  <= dsp_c;
            op_r <= dsp_opmode;
            m_r  <= a1_r * b1_r;
            p_r  <= op_r[7] ? (z_mux - x_mux) : (z_mux + x_mux);
        end
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: arithmetic model of each command, checked every cycle
    initial begin
        logic [7:0]  exp_op;
        logic [47:0] acc, prev_data;
        longint      prod;
        int          cyc, last_issue, remaining, term;
        bit          cur_bias, cur_sub, clear_pending, prev_valid, prev_hs;
        exp_op = 8'h08; acc = '0; prev_data = '0; cyc = 0; last_issue = 0;
        remaining = 0; term = 0; cur_bias = 0; cur_sub = 0;
        clear_pending = 0; prev_valid = 0; prev_hs = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) begin
                exp_q.delete();
                exp_op = 8'h08; remaining = 0; term = 0;
                clear_pending = 0; prev_valid = 0; prev_hs = 0;
            end else begin
                check("opmode", dsp_opmode, exp_op);
                check("cmd_ready_vs_res_valid", cmd_ready & res_valid, 0);
                if (s_ready) check("s_ready_with_terms_left", remaining != 0, 1);
                if (res_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_result: got %h expected none", res_data);
                    end else begin
                        check("result", res_data, exp_q[0]);
                    end
                    check("latency", cyc - last_issue, 4);
                end
                if (res_valid && prev_valid && !prev_hs)
                    check("result_stable", res_data, prev_data);

                exp_op = 8'h08;
                if (clear_pending) begin
                    exp_op = cur_bias ? 8'h0C : 8'h00;
                    last_issue = cyc;
                    clear_pending = 0;
                end
                if (cmd_valid && cmd_ready) begin
                    remaining = int'(cmd_len); term = 0;
                    cur_bias = cmd_bias_en; cur_sub = cmd_sub;
                    acc = cmd_bias_en ? cmd_bias : 48'd0;
                    if (cmd_len == 8'd0) begin
                        clear_pending = 1;
                        exp_q.push_back(acc);
                    end
                end
                if (s_valid && s_ready) begin
                    if (term == 0)
                        exp_op = {cur_sub, 3'b000, cur_bias ? 4'hD : 4'h1};
                    else
                        exp_op = {cur_sub, 7'h09};
                    prod = longint'($signed(s_a)) * longint'($signed(s_b));
                    acc = cur_sub ? acc - 48'(prod) : acc + 48'(prod);
                    term++; remaining--; last_issue = cyc;
                    if (remaining == 0) exp_q.push_back(acc);
                end
                if (res_valid && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                prev_valid = res_valid;
                prev_hs = res_valid && res_ready;
                prev_data = res_data;
            end
        end
    end

    task automatic do_cmd(input int len, input bit ben, input bit sb, input logic [47:0] bias);
        int n = 0;
        cmd_valid = 1'b1; cmd_len = 8'(len); cmd_bias_en = ben; cmd_sub = sb; cmd_bias = bias;
        while (!cmd_ready && n < 50) begin @(posedge CLK); #1; n++; end
        check("cmd_accept_timeout", cmd_ready, 1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0; cmd_bias = 48'd0;
    endtask

    task automatic send_pair(input int a, input int b, input int gap, output logic [7:0] op);
        int n = 0;
        repeat (gap) begin @(posedge CLK); #1; end
        s_valid = 1'b1; s_a = 18'(a); s_b = 18'(b);
        while (!s_ready && n < 50) begin @(posedge CLK); #1; n++; end
        check("s_accept_timeout", s_ready, 1);
        @(posedge CLK); #1;
        s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0;
        op = dsp_opmode;
    endtask

    task automatic get_result(input logic [47:0] exp, input int hold);
        int n = 0;
        while (!res_valid && n < 50) begin @(posedge CLK); #1; n++; end
        check("res_valid_timeout", res_valid, 1);
        check("res_data_literal", res_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_res_data", res_data, exp);
        end
        res_ready = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0;
        check("idle_after_hs", cmd_ready, 1);
        check("res_valid_after_hs", res_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] op0, op1, op2, op3;
        int seen;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_s_ready", s_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 48'd0);
        check("rst_opmode", dsp_opmode, 8'h08);
        check("rst_dsp_a", dsp_a, 0);
        check("rst_dsp_b", dsp_b, 0);
        check("rst_dsp_c", dsp_c, 48'd0);
        check("const_ce_carry", {dsp_ce, dsp_carryin}, 2'b10);
        RST = 1'b0;

        // N=3 add, no bias
        do_cmd(3, 0, 0, 48'd0);
        send_pair(2, 5, 0, op0); send_pair(3, 6, 0, op1); send_pair(4, 7, 0, op2);
        check("op_first_add", op0, 8'h01);
        get_result(48'd56, 0);

        // N=3 add with bias 100, OPMODE sequence 0D 09 09 08
        do_cmd(3, 1, 0, 48'd100);
        send_pair(2, 5, 0, op0); send_pair(3, 6, 0, op1); send_pair(4, 7, 0, op2);
        @(posedge CLK); #1;
        op3 = dsp_opmode;
        check("opseq_0", op0, 8'h0D);
        check("opseq_1", op1, 8'h09);
        check("opseq_2", op2, 8'h09);
        check("opseq_3", op3, 8'h08);
        get_result(48'd156, 0);

        // Subtraction with and without bias
        do_cmd(2, 1, 1, 48'd100);
        send_pair(3, 4, 0, op0); send_pair(5, 1, 0, op1);
        check("op_first_subbias", op0, 8'h8D);
        check("op_later_sub", op1, 8'h89);
        get_result(48'd83, 0);
        do_cmd(2, 0, 1, 48'd100);
        send_pair(3, 4, 0, op0); send_pair(5, 1, 0, op1);
        check("op_first_sub", op0, 8'h81);
        get_result(48'hFFFF_FFFF_FFEF, 0);

        // Bubbles between pairs
        do_cmd(4, 0, 0, 48'd0);
        send_pair(1, 1, 0, op0); send_pair(2, 2, 0, op1);
        send_pair(3, 3, 2, op2); send_pair(4, 4, 5, op3);
        check("s_ready_after_last", s_ready, 0);
        get_result(48'd30, 0);

        // Zero-length commands
        do_cmd(0, 1, 0, 48'd7);
        check("len0_s_ready", s_ready, 0);
        get_result(48'd7, 0);
        do_cmd(0, 0, 0, 48'd55);
        check("len0_nobias_s_ready", s_ready, 0);
        get_result(48'd0, 0);

        // Back-pressure on the result port
        do_cmd(3, 0, 0, 48'd0);
        send_pair(2, 5, 0, op0); send_pair(3, 6, 0, op1); send_pair(4, 7, 0, op2);
        get_result(48'd56, 10);

        // Abort mid-stream, then a fresh command
        do_cmd(4, 0, 0, 48'd0);
        send_pair(1, 1, 0, op0); send_pair(2, 2, 0, op1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_cmd_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (res_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        do_cmd(1, 0, 0, 48'd0);
        send_pair(6, 7, 0, op0);
        get_result(48'd42, 0);

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
